// File: rtl/auto_player.sv
// Auto-mode song sequencer: walks a per-song note ROM, times each note in beats,
// and drives the note-frequency bus with start / pause-resume / stop control.
module auto_player #(
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic [1:0]  song_sel,
  output logic [31:0] fre,
  output logic [1:0]  num,
  output logic [4:0]  note_idx,
  output logic        playing,
  output logic        song_done
);

  // state | meaning
  // IDLE  | silent, waiting for start
  // LOAD  | one-cycle ROM fetch of the current note
  // PLAY  | note sounding, counter running
  // GAP   | articulation silence at the end of a note
  // PAUSE | frozen; saved_q remembers PLAY (0) or GAP (1)
  // DONE  | one-cycle song_done pulse
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0]  MODE_AUTO = 2'd1;
  localparam logic [4:0]  NOTE_END  = 5'd31;
  localparam logic [31:0] GAP_LOAD  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic        saved_q, saved_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] fre_q, fre_d;
  logic [1:0]  num_q, num_d;
  logic [4:0]  idx_q, idx_d;
  logic        playing_q, playing_d;
  logic        done_q, done_d;

  logic [6:0]  rom_e;
  logic [31:0] play_load;
  logic [31:0] cnt_dec;
  logic        step_note;

  // Entry = {note[4:0], beats[1:0]}; anything past a song's end reads as the end marker.
  function automatic logic [6:0] rom_rd(input logic [1:0] s, input logic [4:0] i);
    logic [6:0] e;
    e = {NOTE_END, 2'd0};
    case (s)
      2'd0: case (i)
        5'd0, 5'd1: e = {5'd8, 2'd0};
        5'd2, 5'd3: e = {5'd12, 2'd0};
        5'd4, 5'd5: e = {5'd13, 2'd0};
        5'd6:       e = {5'd12, 2'd1};
        default:    e = {NOTE_END, 2'd0};
      endcase
      2'd1: case (i)
        5'd0, 5'd4, 5'd5, 5'd10: e = {5'd10, 2'd0};
        5'd1, 5'd3, 5'd7, 5'd8:  e = {5'd9, 2'd0};
        5'd2:                    e = {5'd8, 2'd0};
        5'd6:                    e = {5'd10, 2'd1};
        5'd9:                    e = {5'd9, 2'd1};
        5'd11:                   e = {5'd12, 2'd0};
        5'd12:                   e = {5'd12, 2'd1};
        default:                 e = {NOTE_END, 2'd0};
      endcase
      2'd2: case (i)
        5'd0:    e = {5'd5, 2'd0};
        5'd1:    e = {5'd8, 2'd0};
        5'd2:    e = {5'd10, 2'd0};
        5'd3:    e = {5'd12, 2'd0};
        5'd4:    e = {5'd15, 2'd1};
        5'd5:    e = {5'd0, 2'd0};
        5'd6:    e = {5'd15, 2'd3};
        default: e = {NOTE_END, 2'd0};
      endcase
      default: e = {NOTE_END, 2'd0};
    endcase
    return e;
  endfunction

  function automatic logic [31:0] note_freq(input logic [4:0] n);
    logic [31:0] f;
    case (n)
      5'd1:  f = 32'd262;
      5'd2:  f = 32'd294;
      5'd3:  f = 32'd330;
      5'd4:  f = 32'd349;
      5'd5:  f = 32'd392;
      5'd6:  f = 32'd440;
      5'd7:  f = 32'd494;
      5'd8:  f = 32'd523;
      5'd9:  f = 32'd587;
      5'd10: f = 32'd659;
      5'd11: f = 32'd698;
      5'd12: f = 32'd784;
      5'd13: f = 32'd880;
      5'd14: f = 32'd988;
      5'd15: f = 32'd1046;
      5'd16: f = 32'd1175;
      5'd17: f = 32'd1318;
      5'd18: f = 32'd1397;
      5'd19: f = 32'd1568;
      5'd20: f = 32'd1760;
      5'd21: f = 32'd1976;
      default: f = 32'd0;
    endcase
    return f;
  endfunction

  always_comb begin
    rom_e     = rom_rd(num_q, idx_q);
    play_load = (32'(rom_e[1:0]) + 32'd1) * BEAT_CYCLES - GAP_CYCLES - 32'd1;
    cnt_dec   = (cnt_q == 32'd0) ? 32'd0 : cnt_q - 32'd1;
    step_note = 1'b0;
    state_d   = state_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    fre_d     = fre_q;
    num_d     = num_q;
    idx_d     = idx_q;
    playing_d = playing_q;
    done_d    = 1'b0;

    if (stop || mode != MODE_AUTO) begin
      state_d   = S_IDLE;
      fre_d     = 32'd0;
      playing_d = 1'b0;
      cnt_d     = 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          fre_d     = 32'd0;
          playing_d = 1'b0;
          if (start && song_sel != 2'd3) begin
            num_d     = song_sel;
            idx_d     = 5'd0;
            state_d   = S_LOAD;
            playing_d = 1'b1;
          end
        end
        S_LOAD: begin
          if (rom_e[6:2] == NOTE_END) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            playing_d = 1'b0;
            fre_d     = 32'd0;
          end else begin
            state_d = S_PLAY;
            fre_d   = note_freq(rom_e[6:2]);
            cnt_d   = play_load;
          end
        end
        S_PLAY: begin
          // The cycle carrying the pause still counts, so the saved count is already decremented.
          if (pause) begin
            state_d = S_PAUSE;
            saved_d = 1'b0;
            cnt_d   = cnt_dec;
            fre_d   = 32'd0;
          end else if (cnt_q == 32'd0) begin
            if (GAP_CYCLES == 0) begin
              step_note = 1'b1;
            end else begin
              state_d = S_GAP;
              cnt_d   = GAP_LOAD;
              fre_d   = 32'd0;
            end
          end else begin
            cnt_d = cnt_dec;
          end
        end
        S_GAP: begin
          if (pause) begin
            state_d = S_PAUSE;
            saved_d = 1'b1;
            cnt_d   = cnt_dec;
          end else if (cnt_q == 32'd0) begin
            step_note = 1'b1;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        S_PAUSE: begin
          if (pause) begin
            state_d = saved_q ? S_GAP : S_PLAY;
            fre_d   = saved_q ? 32'd0 : note_freq(rom_e[6:2]);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d   = S_IDLE;
          fre_d     = 32'd0;
          playing_d = 1'b0;
        end
      endcase

      if (step_note) begin
        fre_d = 32'd0;
        if (idx_q == 5'd31) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          playing_d = 1'b0;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = S_LOAD;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      saved_q   <= 1'b0;
      cnt_q     <= 32'd0;
      fre_q     <= 32'd0;
      num_q     <= 2'd0;
      idx_q     <= 5'd0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      cnt_q     <= cnt_d;
      fre_q     <= fre_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign fre       = fre_q;
  assign num       = num_q;
  assign note_idx  = idx_q;
  assign playing   = playing_q;
  assign song_done = done_q;

endmodule

// File: tb/tb_auto_player.sv
// Scoreboard bench for auto_player: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_auto_player;

  localparam logic [1:0]  M_FREE  = 2'd0;
  localparam logic [1:0]  M_AUTO  = 2'd1;
  localparam logic [1:0]  M_LEARN = 2'd2;
  localparam logic [31:0] DO  = 32'd523;
  localparam logic [31:0] MI  = 32'd659;
  localparam logic [31:0] SOL = 32'd784;
  localparam logic [31:0] LA  = 32'd880;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = M_FREE;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  song_sel = 2'd0;
  logic [31:0] fre;
  logic [1:0]  num;
  logic [4:0]  note_idx;
  logic        playing;
  logic        song_done;

  typedef struct packed {
    logic [31:0] fre;
    logic [1:0]  num;
    logic [4:0]  idx;
    logic        playing;
    logic        done;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_mon, got_mon;
  int   n_cmp = 0;
  int   n_err = 0;
  event chk_ev;

  auto_player #(.BEAT_CYCLES(8), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .stop(stop), .pause(pause),
    .song_sel(song_sel), .fre(fre), .num(num), .note_idx(note_idx),
    .playing(playing), .song_done(song_done)
  );

  always #5 clk = ~clk;

  always begin
    @(negedge clk or chk_ev);
    if (sb_q.size() > 0) begin
      e_mon   = sb_q.pop_front();
      got_mon = '{fre: fre, num: num, idx: note_idx, playing: playing, done: song_done};
      n_cmp++;
      if (got_mon !== e_mon) begin
        n_err++;
        $display("FAIL cycle_check #%0d t=%0t: got fre=%0d num=%0d idx=%0d playing=%0b done=%0b, want fre=%0d num=%0d idx=%0d playing=%0b done=%0b",
                 n_cmp, $time, got_mon.fre, got_mon.num, got_mon.idx, got_mon.playing, got_mon.done,
                 e_mon.fre, e_mon.num, e_mon.idx, e_mon.playing, e_mon.done);
      end
    end
  end

  task automatic push_exp(input logic [31:0] f, input logic [1:0] n, input logic [4:0] i,
                          input logic p, input logic d);
    exp_t e;
    e.fre = f; e.num = n; e.idx = i; e.playing = p; e.done = d;
    sb_q.push_back(e);
  endtask

  // One clock edge with the currently driven inputs; pulses drop after the edge.
  task automatic exp_cyc(input logic [31:0] f, input logic [1:0] n, input logic [4:0] i,
                         input logic p, input logic d);
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
    push_exp(f, n, i, p, d);
  endtask

  // Full note: PLAY cycles, two gap cycles, then the LOAD of the following note.
  task automatic play_note(input logic [1:0] n, input logic [4:0] i, input logic [31:0] f,
                           input int beats);
    for (int k = 0; k < (beats + 1) * 8 - 2; k++) exp_cyc(f, n, i, 1'b1, 1'b0);
    repeat (2) exp_cyc(32'd0, n, i, 1'b1, 1'b0);
    exp_cyc(32'd0, n, 5'(i + 5'd1), 1'b1, 1'b0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #2;
    push_exp(32'd0, 2'd0, 5'd0, 1'b0, 1'b0);
    ->chk_ev;
    @(negedge clk);
    #1 rst = 1'b0;
    exp_cyc(32'd0, 2'd0, 5'd0, 1'b0, 1'b0);

    // Song 0 end to end
    mode = M_AUTO; song_sel = 2'd0; start = 1'b1;
    exp_cyc(32'd0, 2'd0, 5'd0, 1'b1, 1'b0);
    play_note(2'd0, 5'd0, DO, 0);
    play_note(2'd0, 5'd1, DO, 0);
    play_note(2'd0, 5'd2, SOL, 0);
    play_note(2'd0, 5'd3, SOL, 0);
    play_note(2'd0, 5'd4, LA, 0);
    play_note(2'd0, 5'd5, LA, 0);
    play_note(2'd0, 5'd6, SOL, 1);
    exp_cyc(32'd0, 2'd0, 5'd7, 1'b0, 1'b1);
    exp_cyc(32'd0, 2'd0, 5'd7, 1'b0, 1'b0);
    exp_cyc(32'd0, 2'd0, 5'd7, 1'b0, 1'b0);

    // Rejected starts
    song_sel = 2'd3; start = 1'b1;
    exp_cyc(32'd0, 2'd0, 5'd7, 1'b0, 1'b0);
    if (playing !== 1'b0) begin
      n_err++;
      $display("FAIL direct_check: start with song_sel=3 raised playing");
    end
    song_sel = 2'd0; mode = M_LEARN; start = 1'b1;
    exp_cyc(32'd0, 2'd0, 5'd7, 1'b0, 1'b0);
    if (playing !== 1'b0) begin
      n_err++;
      $display("FAIL direct_check: start outside auto mode raised playing");
    end
    mode = M_AUTO;
    exp_cyc(32'd0, 2'd0, 5'd7, 1'b0, 1'b0);

    // Pause on the third cycle of the first note, resume after 10 silent cycles
    start = 1'b1;
    exp_cyc(32'd0, 2'd0, 5'd0, 1'b1, 1'b0);
    exp_cyc(DO, 2'd0, 5'd0, 1'b1, 1'b0);
    exp_cyc(DO, 2'd0, 5'd0, 1'b1, 1'b0);
    pause = 1'b1;
    exp_cyc(32'd0, 2'd0, 5'd0, 1'b1, 1'b0);
    repeat (9) exp_cyc(32'd0, 2'd0, 5'd0, 1'b1, 1'b0);
    pause = 1'b1;
    repeat (4) exp_cyc(DO, 2'd0, 5'd0, 1'b1, 1'b0);
    repeat (2) exp_cyc(32'd0, 2'd0, 5'd0, 1'b1, 1'b0);
    exp_cyc(32'd0, 2'd0, 5'd1, 1'b1, 1'b0);
    // Start while playing is ignored
    start = 1'b1;
    play_note(2'd0, 5'd1, DO, 0);
    repeat (2) exp_cyc(SOL, 2'd0, 5'd2, 1'b1, 1'b0);
    // Stop beats pause
    stop = 1'b1; pause = 1'b1;
    exp_cyc(32'd0, 2'd0, 5'd2, 1'b0, 1'b0);
    exp_cyc(32'd0, 2'd0, 5'd2, 1'b0, 1'b0);

    // Stop during the gap of the second note, then replay from the top
    start = 1'b1;
    exp_cyc(32'd0, 2'd0, 5'd0, 1'b1, 1'b0);
    play_note(2'd0, 5'd0, DO, 0);
    repeat (6) exp_cyc(DO, 2'd0, 5'd1, 1'b1, 1'b0);
    exp_cyc(32'd0, 2'd0, 5'd1, 1'b1, 1'b0);
    stop = 1'b1;
    exp_cyc(32'd0, 2'd0, 5'd1, 1'b0, 1'b0);
    repeat (3) exp_cyc(32'd0, 2'd0, 5'd1, 1'b0, 1'b0);
    start = 1'b1;
    exp_cyc(32'd0, 2'd0, 5'd0, 1'b1, 1'b0);
    repeat (2) exp_cyc(DO, 2'd0, 5'd0, 1'b1, 1'b0);
    // Leaving auto mode aborts
    mode = M_FREE;
    exp_cyc(32'd0, 2'd0, 5'd0, 1'b0, 1'b0);
    mode = M_AUTO;
    exp_cyc(32'd0, 2'd0, 5'd0, 1'b0, 1'b0);

    // Song 1, then asynchronous reset mid-note
    song_sel = 2'd1; start = 1'b1;
    exp_cyc(32'd0, 2'd1, 5'd0, 1'b1, 1'b0);
    repeat (3) exp_cyc(MI, 2'd1, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    if (fre !== 32'd0 || playing !== 1'b0) begin
      n_err++;
      $display("FAIL direct_check: async reset did not clear fre/playing");
    end
    if (note_idx !== 5'd0 || num !== 2'd0) begin
      n_err++;
      $display("FAIL direct_check: async reset did not clear note_idx/num");
    end
    push_exp(32'd0, 2'd0, 5'd0, 1'b0, 1'b0);
    ->chk_ev;
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) exp_cyc(32'd0, 2'd0, 5'd0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    if (n_cmp == 0) begin
      n_err++;
      $display("FAIL direct_check: scoreboard compared nothing");
    end
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL direct_check: scoreboard not drained (%0d left)", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/auto_player.md
# auto_player

Song sequencer for the electronic-organ design's auto mode. It steps through a built-in note ROM for the selected song, timing each note in beats. It drives the note-frequency bus and song number consumed by the buzzer and the 4-digit seven-segment display. It also supports start, pause/resume and stop, and it aborts when the system leaves auto mode.

## Interface
Parameters:
- BEAT_CYCLES, 25_000_000: clk cycles per beat; must be greater than GAP_CYCLES.
- GAP_CYCLES, 2_500_000: silent articulation cycles at the end of every note; 0 disables the gap.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  system mode using the shared free/auto/learn encoding. The block plays only while mode == auto.
- start  in  1  single-cycle pulse; begins the selected song.
- stop  in  1  single-cycle pulse; aborts playback.
- pause  in  1  single-cycle pulse; toggles pause and resume.
- song_sel  in  2  song index 0..2; the value 3 is invalid.
- fre  out  32  current note frequency, using the shared do_low..si_high constants; 0 means silence.
- num  out  2  latched song number (song1/song2/song3 encoding 0..2).
- note_idx  out  5  ROM index of the current note.
- playing  out  1  high in LOAD, PLAY, GAP and PAUSE.
- song_done  out  1  one-cycle pulse when a song completes naturally.

## Operation
ROM format:
- 3 songs × 32 entries.
- Each entry holds note[4:0] and beats[1:0]:
  - note 0 = rest.
  - note 1-7 = do_low..si_low.
  - note 8-14 = do..si.
  - note 15-21 = do_high..si_high.
  - note 31 = end marker.
  - beats 0..3 encodes 1..4 beats.
- Song 0 is fixed as do,do,sol,sol,la,la,sol. All seven notes are mid octave. Beats are 1,1,1,1,1,1,2, followed by the end marker.
- Songs 1 and 2 are team-chosen tunes of at most 31 notes each.

States: IDLE, LOAD, PLAY, GAP, PAUSE, DONE.
- IDLE: fre=0.
  - start && song_sel!=3 && mode==auto → latch num=song_sel, note_idx=0, go to LOAD.
  - Any other start is ignored.
- LOAD (1 cycle): fre=0; read ROM[num][note_idx].
  - End marker → DONE.
  - Otherwise → PLAY, with the counter loaded to (beats+1)·BEAT_CYCLES − GAP_CYCLES.
- PLAY: fre = frequency of the note (0 for a rest); the counter decrements each cycle.
  - At expiry → GAP, or directly to the next-note step if GAP_CYCLES=0.
- GAP: fre=0 for GAP_CYCLES cycles, then the next-note step.
- Next-note step:
  - If note_idx==31 → DONE.
  - Otherwise note_idx+1 and → LOAD. No wrap-around.
- PAUSE: fre=0. The counter, the interrupted state (PLAY or GAP) and note_idx are frozen. A pause pulse returns to the saved state with the remaining count intact.
- DONE (1 cycle): song_done=1, fre=0 → IDLE. note_idx and num keep their last values.

Priority when events coincide: rst > stop or (mode≠auto) > pause > start.
- Stop, or mode≠auto, takes any non-IDLE state to IDLE on the next edge. fre=0 and playing=0 from that edge on. song_done is not asserted.
- Pause is honoured only in PLAY and GAP (to PAUSE) and in PAUSE (resume). It is ignored in IDLE, LOAD and DONE.
- Start is ignored outside IDLE; restarting requires stop first.
- A counter expiry in the same cycle as pause: the pause wins, and the saved remaining count is 0. On resume the transition completes after 1 cycle.

## Timing
- Reset values: state IDLE, fre=0, num=0, note_idx=0, playing=0, song_done=0, counter=0. Reset mid-song returns to these values immediately (asynchronously).
- Outputs are registered.
- Latency from start: start is sampled at edge N → LOAD during cycle N+1 → fre valid from edge N+2.
- Each note occupies exactly 1 + (beats+1)·BEAT_CYCLES cycles:
  - 1 LOAD cycle with fre=0;
  - (beats+1)·BEAT_CYCLES − GAP_CYCLES cycles with fre valid;
  - GAP_CYCLES cycles with fre=0.
- Time spent in PAUSE adds to these counts; no cycles are lost or duplicated.
- From end-marker LOAD to the song_done pulse: 1 cycle. IDLE follows on the next edge.

## Test plan
Benches use BEAT_CYCLES=8 and GAP_CYCLES=2.
- Reset, then mode=auto, song_sel=0, start pulse → fre=do from edge N+2 for 6 cycles, then 0 for 2 cycles, then 1 LOAD cycle. The sequence repeats for do,sol,sol,la,la. The final sol is held 14 cycles. song_done pulses once 1 cycle after the end-marker LOAD. Total length is 7·9+8 = 71 cycles, then IDLE.
- Pause pulse on the 3rd cycle of the first note → fre=0 and note_idx stays 0 for 10 cycles. Resume pulse → fre=do for exactly 4 more cycles.
- Stop pulse mid-GAP of note 2 → IDLE next edge: playing=0, fre=0, song_done never asserted. A following start replays from note_idx=0.
- Start with song_sel=3, or with mode≠auto → remains IDLE and playing stays 0. Changing mode to free mid-note → IDLE next edge.
- Stop and pause in the same cycle → IDLE, not PAUSE. Start while playing → ignored; note_idx continues normally.
- rst asserted mid-PLAY of song 1 → all outputs return to their reset values without waiting for a clock edge. After release, the block stays in IDLE until start.
